// File: rtl/cnt4b_ctrl.sv
// cnt4b_ctrl: run controller for one 4-bit up/down counter.
// Loads a requested range and direction into the counter, enables counting,
// and counts wrap events (laps). Stops after the programmed number of laps.
// Supports pause and abort. Every output comes straight from a register.
module cnt4b_ctrl #(
  parameter int unsigned LAP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       cfg_min,
  input  logic [3:0]       cfg_max,
  input  logic             cfg_mode,
  input  logic [LAP_W-1:0] cfg_laps,
  input  logic             pause,
  input  logic             abort,
  input  logic [3:0]       cnt_out,
  output logic             cnt_rst,
  output logic             cnt_ss,
  output logic             cnt_mode,
  output logic [3:0]       cnt_min,
  output logic [3:0]       cnt_max,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LAP_W-1:0] lap_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StPause,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic             cnt_rst_q, cnt_rst_d;
  logic             cnt_ss_q, cnt_ss_d;
  logic             mode_q, mode_d;
  logic [3:0]       min_q, min_d;
  logic [3:0]       max_q, max_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [LAP_W-1:0] lap_cnt_q, lap_cnt_d;
  logic [LAP_W-1:0] laps_q, laps_d;

  logic [3:0]       term;
  logic             lap_edge;
  logic [LAP_W-1:0] lap_next;

  // The counter wraps on the same edge it sits at the terminal value while enabled.
  assign term     = mode_q ? max_q : min_q;
  assign lap_edge = cnt_ss_q && (cnt_out == term);
  assign lap_next = lap_cnt_q + LAP_W'(1);

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    min_d     = min_q;
    max_d     = max_q;
    laps_d    = laps_q;
    lap_cnt_d = lap_cnt_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (cfg_min <= cfg_max) begin
            mode_d    = cfg_mode;
            min_d     = cfg_min;
            max_d     = cfg_max;
            laps_d    = cfg_laps;
            lap_cnt_d = '0;
            state_d   = StLoad;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        state_d = abort ? StIdle : StRun;
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (lap_edge) begin
          // A lap coinciding with pause still counts; final lap wins over pause.
          lap_cnt_d = lap_next;
          if ((laps_q != '0) && (lap_next == laps_q)) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else if (pause) begin
            state_d = StPause;
          end
        end else if (pause) begin
          state_d = StPause;
        end
      end
      StPause: begin
        if (abort) begin
          state_d = StIdle;
        end else if (!pause) begin
          state_d = StRun;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Counter controls follow the state being entered so they are valid
    // for the whole cycle spent there.
    busy_d    = (state_d == StLoad) || (state_d == StRun) || (state_d == StPause);
    cnt_ss_d  = (state_d == StRun);
    cnt_rst_d = (state_d == StIdle) || (state_d == StLoad) || (state_d == StDone);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_rst_q <= 1'b1;
      cnt_ss_q  <= 1'b0;
      mode_q    <= 1'b1;
      min_q     <= 4'd0;
      max_q     <= 4'd15;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      lap_cnt_q <= '0;
      laps_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_rst_q <= cnt_rst_d;
      cnt_ss_q  <= cnt_ss_d;
      mode_q    <= mode_d;
      min_q     <= min_d;
      max_q     <= max_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      lap_cnt_q <= lap_cnt_d;
      laps_q    <= laps_d;
    end
  end

  assign cnt_rst  = cnt_rst_q;
  assign cnt_ss   = cnt_ss_q;
  assign cnt_mode = mode_q;
  assign cnt_min  = min_q;
  assign cnt_max  = max_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign lap_cnt  = lap_cnt_q;

endmodule

// File: tb/tb_cnt4b_ctrl.sv
// tb_cnt4b_ctrl: directed bench for cnt4b_ctrl with a behavioural 4-bit counter
// closing the loop. Expected values are hand-derived from the run timing:
// start accepted at E0, counter preloaded at E1, first step at E2.
module tb_cnt4b_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] cfg_min;
  logic [3:0] cfg_max;
  logic       cfg_mode;
  logic [7:0] cfg_laps;
  logic       pause;
  logic       abort;
  logic [3:0] cnt_out;
  logic       cnt_rst;
  logic       cnt_ss;
  logic       cnt_mode;
  logic [3:0] cnt_min;
  logic [3:0] cnt_max;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] lap_cnt;

  int n_checks;
  int n_err;

  // {cnt_rst, cnt_ss, cnt_mode, cnt_min, cnt_max, busy, done, err, lap_cnt}
  localparam logic [21:0] RstVec = {1'b1, 1'b0, 1'b1, 4'd0, 4'd15, 1'b0, 1'b0, 1'b0, 8'd0};
  logic [21:0] out_vec;
  assign out_vec = {cnt_rst, cnt_ss, cnt_mode, cnt_min, cnt_max, busy, done, err, lap_cnt};

  cnt4b_ctrl #(
    .LAP_W(8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .cfg_min (cfg_min),
    .cfg_max (cfg_max),
    .cfg_mode(cfg_mode),
    .cfg_laps(cfg_laps),
    .pause   (pause),
    .abort   (abort),
    .cnt_out (cnt_out),
    .cnt_rst (cnt_rst),
    .cnt_ss  (cnt_ss),
    .cnt_mode(cnt_mode),
    .cnt_min (cnt_min),
    .cnt_max (cnt_max),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .lap_cnt (lap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter model: synchronous preload on cnt_rst, wrap at the bounds.
  always @(posedge clk) begin
    if (cnt_rst) begin
      cnt_out <= cnt_mode ? cnt_min : cnt_max;
    end else if (cnt_ss) begin
      if (cnt_mode) cnt_out <= (cnt_out == cnt_max) ? cnt_min : cnt_out + 4'd1;
      else          cnt_out <= (cnt_out == cnt_min) ? cnt_max : cnt_out - 4'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for exactly one edge (E0); returns 1 time unit after E0.
  task automatic do_start(input logic [3:0] mn, input logic [3:0] mx, input logic md,
                          input logic [7:0] lp);
    cfg_min  = mn;
    cfg_max  = mx;
    cfg_mode = md;
    cfg_laps = lp;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  // Number of edges after E0 until done is seen high; -1 if the bound expires.
  task automatic wait_done(input int limit, output int edges);
    edges = -1;
    for (int k = 1; k <= limit; k++) begin
      step();
      if (done === 1'b1) begin
        edges = k;
        break;
      end
    end
  endtask

  initial begin
    int   e;
    int   pk;
    logic saw;

    n_checks = 0;
    n_err    = 0;
    rst      = 1'b0;
    start    = 1'b0;
    cfg_min  = 4'd0;
    cfg_max  = 4'd0;
    cfg_mode = 1'b0;
    cfg_laps = 8'd0;
    pause    = 1'b0;
    abort    = 1'b0;

    step();
    step();
    chk("reset_vec", 32'(out_vec), 32'(RstVec));
    rst = 1'b1;
    step();
    chk("idle_vec", 32'(out_vec), 32'(RstVec));

    // Up 3..6, two laps: done rises on edge 9 (high in cycle 10 from the start edge).
    do_start(4'd3, 4'd6, 1'b1, 8'd2);
    chk("up_busy", 32'(busy), 32'd1);
    chk("up_cfg", 32'({cnt_mode, cnt_min, cnt_max}), 32'({1'b1, 4'd3, 4'd6}));
    for (int i = 0; i < 8; i++) begin
      logic [3:0] ev;
      ev = 4'(3 + (i % 4));
      step();
      chk("up_seq", 32'({done, cnt_out}), 32'({1'b0, ev}));
    end
    chk("up_lap_mid", 32'(lap_cnt), 32'd1);
    step();
    chk("up_done", 32'({done, busy}), 32'({1'b1, 1'b0}));
    chk("up_laps", 32'(lap_cnt), 32'd2);
    step();
    chk("up_done_pulse", 32'(done), 32'd0);
    chk("up_rest", 32'(cnt_out), 32'd3);
    chk("up_laps_hold", 32'(lap_cnt), 32'd2);

    // Down 2..9, one lap: N=8, done rises on edge 9.
    do_start(4'd2, 4'd9, 1'b0, 8'd1);
    chk("dn_cfg", 32'({cnt_mode, cnt_min, cnt_max}), 32'({1'b0, 4'd2, 4'd9}));
    chk("dn_lap_clear", 32'(lap_cnt), 32'd0);
    wait_done(40, e);
    chk("dn_latency", 32'(e), 32'd9);
    chk("dn_laps", 32'(lap_cnt), 32'd1);
    step();
    chk("dn_reload", 32'({cnt_rst, cnt_out}), 32'({1'b1, 4'd9}));

    // Rejected request: err pulse, nothing else moves.
    do_start(4'd7, 4'd4, 1'b1, 8'd3);
    chk("rej_err", 32'({err, busy}), 32'({1'b1, 1'b0}));
    chk("rej_cfg", 32'({cnt_mode, cnt_min, cnt_max}), 32'({1'b0, 4'd2, 4'd9}));
    chk("rej_laps", 32'(lap_cnt), 32'd1);
    step();
    chk("rej_err_pulse", 32'({err, busy}), 32'd0);

    // Pause for 5 edges when the counter shows 8: done moves from edge 17 to 22.
    do_start(4'd0, 4'd15, 1'b1, 8'd1);
    pk = 0;
    e  = -1;
    for (int k = 1; k <= 80; k++) begin
      step();
      if (pk == 0 && cnt_out == 4'd8) begin
        pause = 1'b1;
        pk    = k;
      end else if (pk != 0 && k == pk + 5) begin
        pause = 1'b0;
      end
      if (pk != 0 && k == pk + 2) chk("pause_ss", 32'({cnt_ss, busy}), 32'({1'b0, 1'b1}));
      if (pk != 0 && k == pk + 6) chk("pause_hold", 32'(cnt_out), 32'd9);
      if (pk != 0 && k == pk + 7) chk("pause_resume", 32'(cnt_out), 32'd10);
      if (done === 1'b1) begin
        e = k;
        break;
      end
    end
    pause = 1'b0;
    chk("pause_latency", 32'(e), 32'd22);
    chk("pause_laps", 32'(lap_cnt), 32'd1);
    step();

    // Endless run 0..15, abort sampled on edge 40: laps at edges 17 and 33.
    do_start(4'd0, 4'd15, 1'b1, 8'd0);
    saw = 1'b0;
    for (int k = 1; k <= 39; k++) begin
      step();
      saw |= done;
      if (k == 5) begin
        start   = 1'b1;
        cfg_min = 4'd9;
        cfg_max = 4'd12;
      end
      if (k == 6) start = 1'b0;
      if (k == 16) chk("ab_lap0", 32'(lap_cnt), 32'd0);
      if (k == 17) chk("ab_lap1", 32'(lap_cnt), 32'd1);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    saw |= done;
    chk("ab_ctrl", 32'({busy, cnt_ss, cnt_rst, done}), 32'({1'b0, 1'b0, 1'b1, 1'b0}));
    chk("ab_laps", 32'(lap_cnt), 32'd2);
    chk("ab_cfg_kept", 32'({cnt_min, cnt_max}), 32'({4'd0, 4'd15}));
    step();
    saw |= done;
    chk("ab_no_done", 32'(saw), 32'd0);
    chk("ab_laps_hold", 32'(lap_cnt), 32'd2);

    // Single-value range, endless: a lap every enabled edge, lap_cnt wraps mod 256.
    do_start(4'd5, 4'd5, 1'b1, 8'd0);
    saw = 1'b0;
    for (int k = 1; k <= 257; k++) begin
      step();
      saw |= done;
      if (k == 256) chk("wrap_255", 32'(lap_cnt), 32'd255);
      if (k == 257) chk("wrap_0", 32'(lap_cnt), 32'd0);
    end
    chk("wrap_no_done", 32'(saw), 32'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // Single-value range, three laps: lap edges 2,3,4; done high in cycle 5.
    do_start(4'd5, 4'd5, 1'b1, 8'd3);
    for (int k = 1; k <= 4; k++) begin
      logic [8:0] ev;
      ev = {(k == 4), 8'(k - 1)};
      step();
      chk("one_seq", 32'({done, lap_cnt}), 32'(ev));
    end
    step();
    chk("one_after", 32'({done, busy, lap_cnt}), 32'({1'b0, 1'b0, 8'd3}));

    // Asynchronous reset in the middle of a down run.
    do_start(4'd1, 4'd14, 1'b0, 8'd0);
    for (int k = 0; k < 10; k++) step();
    chk("rst_pre_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async", 32'(out_vec), 32'(RstVec));
    step();
    chk("rst_hold", 32'(out_vec), 32'(RstVec));
    chk("rst_cnt", 32'(cnt_out), 32'd0);
    rst = 1'b1;
    step();
    chk("rst_idle", 32'(out_vec), 32'(RstVec));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
